// File: rtl/pipe_pkg.sv
// pipe_pkg: shared control-word layout, stage masks and pipeline advance modes.
package pipe_pkg;
    localparam int CW_DEF = 13;
    localparam int CTRL_LOAD_BIT = 1;
    localparam int CTRL_RF_BIT = 0;
    localparam int CTRL_MEMEN_BIT = 2;
    localparam int CTRL_RW_BIT = 3;
    localparam int CTRL_SIZE_BIT = 4;
    localparam logic [CW_DEF-1:0] CTRL_NOP = '0;
    localparam logic [CW_DEF-1:0] MEM_MASK_DEF = 13'h1FFF;
    localparam logic [CW_DEF-1:0] WB_MASK_DEF = 13'h0003;
    typedef enum logic [1:0] {ADV_NORMAL, ADV_FLUSH, ADV_STALL, ADV_HOLD} adv_e;
endpackage

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: W-bit pipeline register with async clear, load enable and bubble (bubble wins).
module pipe_stage_reg #(
    parameter int W = 1
) (
    input  logic         CLK,
    input  logic         CLR,
    input  logic         ld_i,
    input  logic         bubble_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);
    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) q_o <= '0;
        else if (bubble_i) q_o <= '0;
        else if (ld_i) q_o <= d_i;
    end
endmodule

// File: rtl/pipe_ctrl_chain.sv
// pipe_ctrl_chain: IF/ID..MEM/WB control pipeline with load-use stall, branch flush, hold and
// saturating stall/flush counters.
module pipe_ctrl_chain
    import pipe_pkg::*;
#(
    parameter int IW = 32,
    parameter int CW = 13,
    parameter int RW = 4,
    parameter int LOAD_BIT = 1,
    parameter int RF_BIT = 0,
    parameter logic [CW-1:0] MEM_MASK = 13'h1FFF,
    parameter logic [CW-1:0] WB_MASK = 13'h0003,
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             CLR,
    input  logic [IW-1:0]    if_instr,
    input  logic [IW-1:0]    if_pc4,
    input  logic [CW-1:0]    id_ctrl,
    input  logic [RW-1:0]    id_rd,
    input  logic [RW-1:0]    id_rn,
    input  logic [RW-1:0]    id_rm,
    input  logic             id_use_rn,
    input  logic             id_use_rm,
    input  logic             br_taken,
    input  logic             hold,
    output logic [IW-1:0]    id_instr,
    output logic [IW-1:0]    id_pc4,
    output logic [CW-1:0]    ex_ctrl,
    output logic [CW-1:0]    mem_ctrl,
    output logic [CW-1:0]    wb_ctrl,
    output logic [RW-1:0]    ex_rd,
    output logic [RW-1:0]    mem_rd,
    output logic [RW-1:0]    wb_rd,
    output logic             id_v,
    output logic             ex_v,
    output logic             mem_v,
    output logic             wb_v,
    output logic             pc_ld,
    output logic             stall,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    adv_e adv;
    logic hit_rn, hit_rm;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

    always_comb begin
        hit_rn = id_use_rn & (ex_rd == id_rn);
        hit_rm = id_use_rm & (ex_rd == id_rm);
        stall = id_v & ex_v & ex_ctrl[LOAD_BIT] & ex_ctrl[RF_BIT] & (hit_rn | hit_rm);
        adv = hold ? ADV_HOLD : stall ? ADV_STALL : (br_taken & id_v) ? ADV_FLUSH : ADV_NORMAL;
        pc_ld = ~stall & ~hold;
        stall_cnt_d = (adv == ADV_STALL && stall_cnt_q != CNT_MAX) ? stall_cnt_q + CNT_ONE : stall_cnt_q;
        flush_cnt_d = (adv == ADV_FLUSH && flush_cnt_q != CNT_MAX) ? flush_cnt_q + CNT_ONE : flush_cnt_q;
    end

    // A flush squashes the wrong-path fetch; the branch itself still moves on into EX.
    pipe_stage_reg #(.W(2*IW+1)) u_ifid (
        .CLK(CLK), .CLR(CLR),
        .ld_i(adv == ADV_NORMAL), .bubble_i(adv == ADV_FLUSH),
        .d_i({if_instr, if_pc4, 1'b1}), .q_o({id_instr, id_pc4, id_v})
    );

    pipe_stage_reg #(.W(CW+RW+1)) u_idex (
        .CLK(CLK), .CLR(CLR),
        .ld_i(adv != ADV_HOLD), .bubble_i(adv == ADV_STALL),
        .d_i({id_ctrl & {CW{id_v}}, id_rd, id_v}), .q_o({ex_ctrl, ex_rd, ex_v})
    );

    pipe_stage_reg #(.W(CW+RW+1)) u_exmem (
        .CLK(CLK), .CLR(CLR),
        .ld_i(adv != ADV_HOLD), .bubble_i(1'b0),
        .d_i({ex_ctrl & MEM_MASK, ex_rd, ex_v}), .q_o({mem_ctrl, mem_rd, mem_v})
    );

    pipe_stage_reg #(.W(CW+RW+1)) u_memwb (
        .CLK(CLK), .CLR(CLR),
        .ld_i(adv != ADV_HOLD), .bubble_i(1'b0),
        .d_i({mem_ctrl & WB_MASK, mem_rd, mem_v}), .q_o({wb_ctrl, wb_rd, wb_v})
    );

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
endmodule
